// File: rtl/lzx_vm_pkg.sv
// Shared types and constants for the lzx vending-machine controller.
// Holds the FSM state encoding, the coin code values and a small helper
// used for the credit-width elaboration check.
package lzx_vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_REFUND  = 3'd4
    } vm_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN1     = 2'b01;
    localparam logic [1:0] COIN2     = 2'b10;
    localparam logic [1:0] COIN3     = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lzx_vm_coin_dec.sv
// Coin decoder: maps the 2-bit coin code to its credit value and a valid flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the FSM decides whether a decoded coin is accepted.
// Ports: coin_in (coin code), coin_val (credit units), coin_vld (a coin is present).
module lzx_vm_coin_dec
    import lzx_vm_pkg::*;
#(
    parameter int CREDIT_W  = 5,
    parameter int COIN1_VAL = 1,
    parameter int COIN2_VAL = 2,
    parameter int COIN3_VAL = 10
) (
    input  logic [1:0]          coin_in,
    output logic [CREDIT_W-1:0] coin_val,
    output logic                coin_vld
);

    always_comb begin
        coin_val = '0;
        coin_vld = 1'b0;
        case (coin_in)
            COIN1: begin
                coin_val = CREDIT_W'(COIN1_VAL);
                coin_vld = 1'b1;
            end
            COIN2: begin
                coin_val = CREDIT_W'(COIN2_VAL);
                coin_vld = 1'b1;
            end
            COIN3: begin
                coin_val = CREDIT_W'(COIN3_VAL);
                coin_vld = 1'b1;
            end
            default: begin
                coin_val = '0;
                coin_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lzx_vm_param.sv
// Vending-machine controller: accumulates coin credit, vends at PRICE, pays change/refunds serially.
// Latency: coin completing the price -> D_out the next cycle, first change pulse the cycle after.
// Backpressure: coins arriving while busy (or with cancel) are dropped and flagged on coin_rej.
// Ports: clk/rst_n, In (coin code), cancel (refund request); D_out, C, coin_rej, busy, credit.
module lzx_vm_param
    import lzx_vm_pkg::*;
#(
    parameter int PRICE     = 3,
    parameter int COIN1_VAL = 1,
    parameter int COIN2_VAL = 2,
    parameter int COIN3_VAL = 10,
    parameter int CREDIT_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          In,
    input  logic                cancel,
    output logic                D_out,
    output logic                C,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int MAX_COIN = max3(COIN1_VAL, COIN2_VAL, COIN3_VAL);

    // Largest credit ever held is PRICE-1 plus the biggest coin; it must fit
    // so the accumulator can never wrap.
    generate
        if (PRICE < 1) begin : g_bad_price
            $error("lzx_vm_param: PRICE must be >= 1");
        end
        if ((PRICE - 1 + MAX_COIN) > ((2 ** CREDIT_W) - 1)) begin : g_bad_width
            $error("lzx_vm_param: CREDIT_W too narrow for PRICE-1+max coin value");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    vm_state_t             state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_rej_q, coin_rej_d;
    logic [CREDIT_W-1:0]   coin_val;
    logic                  coin_vld;
    logic [CREDIT_W-1:0]   cn;

    lzx_vm_coin_dec #(
        .CREDIT_W  (CREDIT_W),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL),
        .COIN3_VAL (COIN3_VAL)
    ) u_coin_dec (
        .coin_in  (In),
        .coin_val (coin_val),
        .coin_vld (coin_vld)
    );

    // State, credit and reject-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    // Next-state and credit update.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_rej_d = 1'b0;
        // Cannot overflow: credit is below PRICE whenever a coin is accepted.
        cn         = credit_q + coin_val;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (cancel) begin
                    // Cancel takes priority; a coin on the same edge is bounced.
                    coin_rej_d = coin_vld;
                    state_d    = (credit_q != '0) ? ST_REFUND : ST_IDLE;
                end else if (coin_vld) begin
                    credit_d = cn;
                    state_d  = (cn >= PRICE_C) ? ST_VEND : ST_COLLECT;
                end
            end
            ST_VEND: begin
                coin_rej_d = coin_vld;
                credit_d   = credit_q - PRICE_C;
                state_d    = (credit_q == PRICE_C) ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE, ST_REFUND: begin
                coin_rej_d = coin_vld;
                credit_d   = credit_q - ONE_C;
                if (credit_q == ONE_C) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        D_out    = (state_q == ST_VEND);
        C        = (state_q == ST_CHANGE) || (state_q == ST_REFUND);
        busy     = (state_q == ST_VEND) || (state_q == ST_CHANGE) || (state_q == ST_REFUND);
        coin_rej = coin_rej_q;
        credit   = credit_q;
    end

endmodule
